// File: rtl/axi_ic_pkg.sv
// Shared types and helpers for the AXI interconnect write-data scheduling blocks.
package axi_ic_pkg;

  // W-channel scheduler states: waiting for a queued burst, or streaming one burst.
  typedef enum logic {
    WS_IDLE,
    WS_BURST
  } wd_sched_state_t;

  // Master-index width; a single master still needs a 1-bit index.
  function automatic int unsigned calc_mid_w(int unsigned num_masters);
    return (num_masters > 1) ? $clog2(num_masters) : 1;
  endfunction

endpackage

// File: rtl/wd_order_fifo.sv
// Order queue of master IDs: a small ring buffer with a registered occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module wd_order_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // When full and popping, the write slot equals the read slot; the head is read
  // combinationally this cycle, so overwriting it at the edge is safe.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy next-state; pointers wrap through their power-of-2 width.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + IDX_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + IDX_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are only observed through count-qualified pops, so no reset.
  always_ff @(posedge ACLK) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/wd_order_scheduler.sv
// W-channel scheduler for one slave port: grants the W channel to masters in the
// order their AW bursts were accepted, holding the grant through the WLAST beat.
module wd_order_scheduler
  import axi_ic_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ORDER_DEPTH = 4,
  localparam int unsigned MID_W  = calc_mid_w(NUM_MASTERS),
  localparam int unsigned CNT_W  = $clog2(ORDER_DEPTH) + 1,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  // AW-side order capture
  input  logic                          aw_push,
  input  logic [MID_W-1:0]              aw_push_id,
  output logic                          order_full,
  output logic [CNT_W-1:0]              order_count,
  output logic                          overflow_err,
  // Master-side W channels
  input  logic [NUM_MASTERS-1:0]        S_WVALID,
  input  logic [NUM_MASTERS*DATA_W-1:0] S_WDATA,
  input  logic [NUM_MASTERS*STRB_W-1:0] S_WSTRB,
  input  logic [NUM_MASTERS-1:0]        S_WLAST,
  output logic [NUM_MASTERS-1:0]        S_WREADY,
  // Slave-side W channel
  output logic                          M_WVALID,
  output logic [DATA_W-1:0]             M_WDATA,
  output logic [STRB_W-1:0]             M_WSTRB,
  output logic                          M_WLAST,
  input  logic                          M_WREADY,
  // Write-response side notification
  output logic                          burst_done,
  output logic [MID_W-1:0]              burst_done_id
);

  wd_sched_state_t  state_q, state_d;
  logic [MID_W-1:0] cur_id_q, cur_id_d;
  logic             burst_done_q;
  logic [MID_W-1:0] burst_done_id_q;
  logic             overflow_q, overflow_d;

  logic [MID_W-1:0] fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             last_hs;

  // Pop decision uses the registered count, so a fresh push is seen a cycle later.
  assign pop = (state_q == WS_IDLE) && !fifo_empty;

  wd_order_fifo #(
    .WIDTH (MID_W),
    .DEPTH (ORDER_DEPTH)
  ) u_order_fifo (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .push_i  (aw_push),
    .pop_i   (pop),
    .din_i   (aw_push_id),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign order_full  = fifo_full;
  assign order_count = fifo_count;

  // A push is lost only when the queue is full and nothing leaves this cycle.
  assign overflow_d = overflow_q | (aw_push && fifo_full && !pop);

  // FSM next-state plus the W mux/demux; everything is quiet outside a burst.
  // An out-of-range cur_id matches no master, so that slot stalls with no grant.
  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    last_hs  = 1'b0;
    M_WVALID = 1'b0;
    M_WDATA  = '0;
    M_WSTRB  = '0;
    M_WLAST  = 1'b0;
    S_WREADY = '0;
    unique case (state_q)
      WS_IDLE: begin
        if (pop) begin
          cur_id_d = fifo_dout;
          state_d  = WS_BURST;
        end
      end
      WS_BURST: begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (cur_id_q == MID_W'(i)) begin
            M_WVALID    = S_WVALID[i];
            M_WDATA     = S_WDATA[i*DATA_W +: DATA_W];
            M_WSTRB     = S_WSTRB[i*STRB_W +: STRB_W];
            M_WLAST     = S_WLAST[i];
            S_WREADY[i] = M_WREADY;
          end
        end
        last_hs = M_WVALID && M_WREADY && M_WLAST;
        if (last_hs) begin
          state_d = WS_IDLE;
        end
      end
    endcase
  end

  // State, current grant, completion pulse and sticky overflow flag.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q         <= WS_IDLE;
      cur_id_q        <= '0;
      burst_done_q    <= 1'b0;
      burst_done_id_q <= '0;
      overflow_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_id_q     <= cur_id_d;
      burst_done_q <= last_hs;
      overflow_q   <= overflow_d;
      if (last_hs) begin
        burst_done_id_q <= cur_id_q;
      end
    end
  end

  assign burst_done    = burst_done_q;
  assign burst_done_id = burst_done_id_q;
  assign overflow_err  = overflow_q;

endmodule

// File: tb/tb_wd_order_scheduler.sv
// Self-checking bench for wd_order_scheduler: a fixed vector table for a single
// burst, directed multi-cycle sequences, and randomized traffic against a
// queue-based reference model.
module tb_wd_order_scheduler;

  localparam int NM    = 2;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 4;
  localparam int MID_W = 1;
  localparam int CNT_W = 3;

  logic              ACLK = 1'b0;
  logic              ARESETN;
  logic              aw_push;
  logic [MID_W-1:0]  aw_push_id;
  logic              order_full;
  logic [CNT_W-1:0]  order_count;
  logic              overflow_err;
  logic [NM-1:0]     S_WVALID;
  logic [NM*DW-1:0]  S_WDATA;
  logic [NM*SW-1:0]  S_WSTRB;
  logic [NM-1:0]     S_WLAST;
  logic [NM-1:0]     S_WREADY;
  logic              M_WVALID;
  logic [DW-1:0]     M_WDATA;
  logic [SW-1:0]     M_WSTRB;
  logic              M_WLAST;
  logic              M_WREADY;
  logic              burst_done;
  logic [MID_W-1:0]  burst_done_id;

  wd_order_scheduler #(
    .NUM_MASTERS (NM),
    .DATA_W      (DW),
    .ORDER_DEPTH (DEPTH)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .aw_push       (aw_push),
    .aw_push_id    (aw_push_id),
    .order_full    (order_full),
    .order_count   (order_count),
    .overflow_err  (overflow_err),
    .S_WVALID      (S_WVALID),
    .S_WDATA       (S_WDATA),
    .S_WSTRB       (S_WSTRB),
    .S_WLAST       (S_WLAST),
    .S_WREADY      (S_WREADY),
    .M_WVALID      (M_WVALID),
    .M_WDATA       (M_WDATA),
    .M_WSTRB       (M_WSTRB),
    .M_WLAST       (M_WLAST),
    .M_WREADY      (M_WREADY),
    .burst_done    (burst_done),
    .burst_done_id (burst_done_id)
  );

  always #5 ACLK = ~ACLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending IDs in a queue, current grant (-1 when none).
  int m_q[$];
  int m_cur;
  bit m_bd;
  int m_bdid;
  bit m_ovf;
  int grants[$];

  typedef struct {
    logic             push;
    logic [MID_W-1:0] id;
    logic             v1;
    logic             l1;
    logic [31:0]      d1;
    logic             e_mv;
    logic [NM-1:0]    e_wr;
    logic             e_ml;
    logic [31:0]      e_md;
    logic [CNT_W-1:0] e_cnt;
    logic             e_bd;
    logic [MID_W-1:0] e_bdid;
  } vec_t;

  vec_t tbl[8];
  int   tbl_idx = -1;

  function automatic vec_t mk(logic push, logic [MID_W-1:0] id, logic v1, logic l1,
                              logic [31:0] d1, logic e_mv, logic [NM-1:0] e_wr,
                              logic e_ml, logic [31:0] e_md, logic [CNT_W-1:0] e_cnt,
                              logic e_bd, logic [MID_W-1:0] e_bdid);
    vec_t v;
    v.push = push; v.id = id; v.v1 = v1; v.l1 = l1; v.d1 = d1;
    v.e_mv = e_mv; v.e_wr = e_wr; v.e_ml = e_ml; v.e_md = e_md;
    v.e_cnt = e_cnt; v.e_bd = e_bd; v.e_bdid = e_bdid;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cur  = -1;
    m_bd   = 1'b0;
    m_bdid = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic set_m(int i, logic v, logic l, logic [31:0] d);
    S_WVALID[i]        = v;
    S_WLAST[i]         = l;
    S_WDATA[i*DW +: DW] = d;
    S_WSTRB[i*SW +: SW] = d[SW-1:0];
  endtask

  task automatic rand_data();
    for (int i = 0; i < NM; i++) begin
      S_WDATA[i*DW +: DW] = $urandom;
      S_WSTRB[i*SW +: SW] = SW'($urandom);
    end
  endtask

  task automatic check_outputs();
    logic          ev, el;
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
    logic [NM-1:0] er;
    ev = 1'b0; el = 1'b0; ed = '0; es = '0; er = '0;
    if (m_cur >= 0 && m_cur < NM) begin
      ev        = S_WVALID[m_cur];
      el        = S_WLAST[m_cur];
      ed        = S_WDATA[m_cur*DW +: DW];
      es        = S_WSTRB[m_cur*SW +: SW];
      er[m_cur] = M_WREADY;
    end
    chk("M_WVALID", 64'(M_WVALID), 64'(ev));
    chk("M_WDATA", 64'(M_WDATA), 64'(ed));
    chk("M_WSTRB", 64'(M_WSTRB), 64'(es));
    chk("M_WLAST", 64'(M_WLAST), 64'(el));
    chk("S_WREADY", 64'(S_WREADY), 64'(er));
    chk("order_count", 64'(order_count), 64'(m_q.size()));
    chk("order_full", 64'(order_full), 64'(m_q.size() == DEPTH));
    chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
    chk("burst_done", 64'(burst_done), 64'(m_bd));
    if (m_bd) chk("burst_done_id", 64'(burst_done_id), 64'(m_bdid));
  endtask

  // Advance the model across one rising edge using the inputs held this cycle.
  task automatic model_advance();
    bit hs, pop;
    int sz;
    if (!ARESETN) begin
      model_reset();
      return;
    end
    hs  = (m_cur >= 0) && (m_cur < NM) && S_WVALID[m_cur] && M_WREADY && S_WLAST[m_cur];
    pop = (m_cur < 0) && (m_q.size() > 0);
    sz  = m_q.size();
    m_bd = hs;
    if (hs) m_bdid = m_cur;
    if (aw_push && sz == DEPTH && !pop) m_ovf = 1'b1;
    if (hs) m_cur = -1;
    if (pop) m_cur = m_q.pop_front();
    if (aw_push && (sz < DEPTH || pop)) m_q.push_back(int'(aw_push_id));
  endtask

  task automatic table_check(int k);
    chk("tbl_mwvalid", 64'(M_WVALID), 64'(tbl[k].e_mv));
    chk("tbl_swready", 64'(S_WREADY), 64'(tbl[k].e_wr));
    chk("tbl_mwlast", 64'(M_WLAST), 64'(tbl[k].e_ml));
    chk("tbl_mwdata", 64'(M_WDATA), 64'(tbl[k].e_md));
    chk("tbl_count", 64'(order_count), 64'(tbl[k].e_cnt));
    chk("tbl_bdone", 64'(burst_done), 64'(tbl[k].e_bd));
    if (tbl[k].e_bd) chk("tbl_bdone_id", 64'(burst_done_id), 64'(tbl[k].e_bdid));
  endtask

  // One clock: sample on the falling edge, then step past the rising edge.
  task automatic step();
    @(negedge ACLK);
    if (M_WVALID && M_WREADY && M_WLAST) begin
      for (int i = 0; i < NM; i++) if (S_WREADY[i]) grants.push_back(i);
    end
    if (tbl_idx >= 0) table_check(tbl_idx);
    check_outputs();
    model_advance();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_grants(string name, int exp[$]);
    chk({name, "_len"}, 64'(grants.size()), 64'(exp.size()));
    for (int k = 0; k < exp.size(); k++) begin
      chk({name, "_id"}, 64'((k < grants.size()) ? grants[k] : -1), 64'(exp[k]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ord[$];
    ARESETN = 1'b0; aw_push = 1'b0; aw_push_id = '0; M_WREADY = 1'b0;
    S_WVALID = '0; S_WLAST = '0; S_WDATA = '0; S_WSTRB = '0;
    model_reset();
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;

    // Single burst from master 1; master 0 holds a valid last beat that must never leak.
    tbl[0] = mk(1, 1, 1, 0, 32'hC0DE_0000, 0, 2'b00, 0, 32'h0,          0, 0, 0);
    tbl[1] = mk(0, 0, 1, 0, 32'hC0DE_0000, 0, 2'b00, 0, 32'h0,          1, 0, 0);
    tbl[2] = mk(0, 0, 1, 0, 32'hC0DE_0000, 1, 2'b10, 0, 32'hC0DE_0000, 0, 0, 0);
    tbl[3] = mk(0, 0, 1, 0, 32'hC0DE_0001, 1, 2'b10, 0, 32'hC0DE_0001, 0, 0, 0);
    tbl[4] = mk(0, 0, 1, 0, 32'hC0DE_0002, 1, 2'b10, 0, 32'hC0DE_0002, 0, 0, 0);
    tbl[5] = mk(0, 0, 1, 1, 32'hC0DE_0003, 1, 2'b10, 1, 32'hC0DE_0003, 0, 0, 0);
    tbl[6] = mk(0, 0, 0, 0, 32'h0,         0, 2'b00, 0, 32'h0,          0, 1, 1);
    tbl[7] = mk(0, 0, 0, 0, 32'h0,         0, 2'b00, 0, 32'h0,          0, 0, 0);
    M_WREADY = 1'b1;
    for (int k = 0; k < 8; k++) begin
      aw_push    = tbl[k].push;
      aw_push_id = tbl[k].id;
      set_m(0, 1'b1, 1'b1, 32'h0BAD_0000);
      set_m(1, tbl[k].v1, tbl[k].l1, tbl[k].d1);
      tbl_idx = k;
      step();
    end
    tbl_idx = -1;

    // Ordering: pushes 0,1,0 back to back, single-beat bursts, both masters ready.
    grants.delete();
    S_WVALID = '1; S_WLAST = '1; M_WREADY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      aw_push = 1'b1; aw_push_id = MID_W'(k % 2);
      rand_data();
      step();
    end
    aw_push = 1'b0;
    repeat (10) begin rand_data(); step(); end
    exp_ord = '{0, 1, 0};
    check_grants("order", exp_ord);

    // Backpressure on a 2-beat burst from master 1.
    S_WVALID = '0; S_WLAST = '0;
    set_m(1, 1'b1, 1'b0, 32'h1111_2222);
    aw_push = 1'b1; aw_push_id = 1'b1; step();
    aw_push = 1'b0; step();
    M_WREADY = 1'b1; step();
    set_m(1, 1'b1, 1'b1, 32'h3333_4444);
    M_WREADY = 1'b0; step();
    chk("bp_no_done_while_stalled", 64'(burst_done), 64'(0));
    M_WREADY = 1'b1; step();
    chk("bp_done_after_last", 64'(burst_done), 64'(1));
    chk("bp_done_id", 64'(burst_done_id), 64'(1));
    set_m(1, 1'b0, 1'b0, 32'h0);
    M_WREADY = 1'b0; step();
    chk("bp_done_one_cycle", 64'(burst_done), 64'(0));

    // Full boundary: no W traffic so only the first ID gets popped.
    S_WVALID = '0; S_WLAST = '0; M_WREADY = 1'b1;
    exp_ord = '{0, 1, 1, 0, 1};
    for (int k = 0; k < 5; k++) begin
      aw_push = 1'b1; aw_push_id = MID_W'(exp_ord[k]); step();
    end
    chk("full_count", 64'(order_count), 64'(DEPTH));
    chk("full_flag", 64'(order_full), 64'(1));
    aw_push_id = 1'b0; step();
    chk("full_overflow", 64'(overflow_err), 64'(1));
    chk("full_count_after_drop", 64'(order_count), 64'(DEPTH));
    aw_push = 1'b0;
    grants.delete();
    S_WVALID = '1; S_WLAST = '1; rand_data();
    step();
    aw_push = 1'b1; aw_push_id = 1'b0; step();
    aw_push = 1'b0;
    chk("full_push_pop_count", 64'(order_count), 64'(DEPTH));
    repeat (12) begin rand_data(); step(); end
    exp_ord = '{0, 1, 1, 0, 1, 0};
    check_grants("full_order", exp_ord);

    // Reset mid-burst with one more entry queued behind it.
    S_WVALID = '0; S_WLAST = '0; M_WREADY = 1'b1;
    set_m(1, 1'b1, 1'b0, 32'h5555_0000);
    aw_push = 1'b1; aw_push_id = 1'b1; step();
    aw_push_id = 1'b0; step();
    aw_push = 1'b0; step();
    step();
    ARESETN = 1'b0;
    model_reset();
    #1;
    chk("rst_count", 64'(order_count), 64'(0));
    chk("rst_full", 64'(order_full), 64'(0));
    chk("rst_overflow", 64'(overflow_err), 64'(0));
    chk("rst_mwvalid", 64'(M_WVALID), 64'(0));
    chk("rst_swready", 64'(S_WREADY), 64'(0));
    chk("rst_bdone", 64'(burst_done), 64'(0));
    chk("rst_bdone_id", 64'(burst_done_id), 64'(0));
    step();
    step();
    ARESETN = 1'b1;
    set_m(0, 1'b1, 1'b1, 32'h7777_0000);
    aw_push = 1'b1; aw_push_id = 1'b0; step();
    aw_push = 1'b0; step();
    chk("post_rst_grant_ready", 64'(S_WREADY), 64'(2'b01));
    chk("post_rst_grant_valid", 64'(M_WVALID), 64'(1));
    step();
    S_WVALID = '0;
    step();

    // Randomized traffic against the model.
    repeat (500) begin
      aw_push    = ($urandom_range(0, 2) == 0);
      aw_push_id = MID_W'($urandom_range(0, NM - 1));
      for (int i = 0; i < NM; i++) begin
        set_m(i, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), $urandom);
      end
      M_WREADY = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
